uart_rx_fifo: RTL

Buffered UART receive endpoint, the receive-side counterpart to the transmit path. It takes the asynchronous serial line, recovers frames using 16x oversampling with majority-vote sampling, and checks the stop bit and an optional parity bit. Good bytes go into a show-ahead FIFO, which drains over a valid/ready stream interface. It sits between the external RX pin and downstream byte consumers, such as a command parser.

---
 rtl/uart_rx_fifo.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver: 16x oversampled, majority-voted frame recovery feeding a
// show-ahead FIFO drained over a valid/ready stream.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int baud_rate  = 9600,
  parameter int clk_freq   = 50000000,
  parameter int FIFO_DEPTH = 8,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             data_rx,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             busy,
  output logic                             frame_err,
  output logic                             parity_err,
  output logic                             overrun,
  input  logic                             err_clr
);
  localparam int DIV = clk_freq / (baud_rate * 16);
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // data_rx is asynchronous; sync chain idles high like the line
  logic [1:0] sync;
  logic       line;
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], data_rx};
  assign line = sync[1];

  logic [DCW-1:0] div_cnt;
  logic           tick;
  assign tick = (div_cnt == DCW'(DIV - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DCW'(1);

  state_t                state;
  logic [3:0]            s;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic [2:0]            votes;
  logic                  par_bad;
  logic                  maj_full, stop_bit, resolve, push;

  assign maj_full = maj3(votes[0], votes[1], votes[2]);
  // stop is resolved at s=9, so the third vote is the live line
  assign stop_bit = maj3(votes[0], votes[1], line);
  assign resolve  = tick && (state == STOP) && (s == 4'd9);
  assign push     = resolve && stop_bit && !par_bad;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      s       <= '0;
      idx     <= '0;
      shreg   <= '0;
      votes   <= '0;
      par_bad <= 1'b0;
    end else if (tick) begin
      if (state == IDLE) begin
        if (!line) begin
          state   <= START;
          s       <= '0;
          par_bad <= 1'b0;
        end
      end else begin
        s <= s + 4'd1;
        if (s == 4'd7) votes[0] <= line;
        if (s == 4'd8) votes[1] <= line;
        if (s == 4'd9) votes[2] <= line;
        case (state)
          START: if (s == 4'd15) begin
            state <= maj_full ? IDLE : DATA;
            idx   <= '0;
          end
          DATA: if (s == 4'd15) begin
            shreg[idx] <= maj_full;
            if (idx == IW'(DATA_WIDTH - 1)) state <= PARITY_EN ? PARITY : STOP;
            else                            idx   <= idx + IW'(1);
          end
          PARITY: if (s == 4'd15) begin
            par_bad <= (maj_full != (^shreg ^ PARITY_ODD));
            state   <= STOP;
          end
          STOP: if (s == 4'd9) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  full, pop, wr_en;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign pop   = m_valid && m_ready;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign m_valid    = (count != '0);
  assign m_data     = m_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;

  // a new error in the same cycle as err_clr keeps the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= (resolve && !stop_bit)           || (frame_err  && !err_clr);
      parity_err <= (resolve && stop_bit && par_bad) || (parity_err && !err_clr);
      overrun    <= (push && full && !pop)           || (overrun    && !err_clr);
    end
  end
endmodule
